// File: rtl/rob_commit.sv
// In-order retire unit for the reorder buffer: allocates at the tail, accepts
// write-back results, and retires ready head entries to the register file.
module rob_commit #(
    parameter int ROB_DEPTH = 8,
    parameter int IDX_W     = 3,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              commit_stall,
    output logic              commit_valid,
    output logic [IDX_W-1:0]  commit_idx,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [IDX_W:0]    rob_count,
    output logic              rob_empty,
    output logic              wb_err
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] ready_q, ready_d;
    logic [REG_W-1:0]     rd_q    [ROB_DEPTH];
    logic [REG_W-1:0]     rd_d    [ROB_DEPTH];
    logic [DATA_W-1:0]    value_q [ROB_DEPTH];
    logic [DATA_W-1:0]    value_d [ROB_DEPTH];
    logic [IDX_W-1:0]     head_q, head_d;
    logic [IDX_W-1:0]     tail_q, tail_d;
    logic [IDX_W:0]       count_q, count_d;
    logic                 commit_valid_q, commit_valid_d;
    logic [IDX_W-1:0]     commit_idx_q, commit_idx_d;
    logic                 rf_we_q, rf_we_d;
    logic [REG_W-1:0]     rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;
    logic                 wb_err_q, wb_err_d;
    logic                 do_alloc;
    logic                 do_commit;
    logic                 wb_ok;

    assign alloc_ready  = (count_q < FULL_COUNT);
    assign alloc_idx    = tail_q;
    assign commit_valid = commit_valid_q;
    assign commit_idx   = commit_idx_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign rob_count    = count_q;
    assign rob_empty    = (count_q == '0);
    assign wb_err       = wb_err_q;

    always_comb begin
        do_alloc  = alloc_valid && alloc_ready;
        do_commit = busy_q[head_q] && ready_q[head_q] && !commit_stall;
        wb_ok     = busy_q[wb_idx] && !ready_q[wb_idx];

        busy_d         = busy_q;
        ready_d        = ready_q;
        rd_d           = rd_q;
        value_d        = value_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_idx_d   = commit_idx_q;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        wb_err_d       = wb_err_q;
        commit_valid_d = do_commit;
        rf_we_d        = do_commit && (rd_q[head_q] != '0);

        if (do_commit) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
            commit_idx_d    = head_q;
            rf_waddr_d      = rd_q[head_q];
            rf_wdata_d      = value_q[head_q];
        end

        // The tail entry is never busy while not full, so this cannot collide with the commit above
        if (do_alloc) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            rd_d[tail_q]    = alloc_rd;
            tail_d          = tail_q + IDX_W'(1);
        end

        if (wb_valid) begin
            if (wb_ok) begin
                value_d[wb_idx] = wb_value;
                ready_d[wb_idx] = 1'b1;
            end else begin
                wb_err_d = 1'b1;
            end
        end

        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + (IDX_W+1)'(1);
            2'b01:   count_d = count_q - (IDX_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            ready_q        <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_idx_q   <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            wb_err_q       <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            rd_q           <= rd_d;
            value_q        <= value_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_idx_q   <= commit_idx_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            wb_err_q       <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: table-driven vectors, hand-written corner
// sequences, and randomized traffic against a queue-based program-order model.
module tb_rob_commit;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        wb_valid;
    logic [2:0]  wb_idx;
    logic [31:0] wb_value;
    logic        commit_stall;
    logic        commit_valid;
    logic [2:0]  commit_idx;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rob_count;
    logic        rob_empty;
    logic        wb_err;

    int n_cmp;
    int n_fail;

    // Reference model: in-flight tags kept in program order
    int          m_q[$];
    logic        m_rdy [DEPTH];
    logic [4:0]  m_rd  [DEPTH];
    logic [31:0] m_val [DEPTH];
    int          m_tail;
    logic        m_err;
    logic        e_cv;
    logic [2:0]  e_cidx;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic        wv;
        logic [2:0]  wi;
        logic [31:0] wd;
        logic        st;
        logic [3:0]  e_count;
        logic        e_cv;
        logic [2:0]  e_cidx;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[7];

    rob_commit #(
        .ROB_DEPTH(8),
        .IDX_W    (3),
        .DATA_W   (32),
        .REG_W    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .alloc_idx   (alloc_idx),
        .wb_valid    (wb_valid),
        .wb_idx      (wb_idx),
        .wb_value    (wb_value),
        .commit_stall(commit_stall),
        .commit_valid(commit_valid),
        .commit_idx  (commit_idx),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rob_count   (rob_count),
        .rob_empty   (rob_empty),
        .wb_err      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_rdy[i] = 1'b0;
            m_rd[i]  = '0;
            m_val[i] = '0;
        end
        m_tail  = 0;
        m_err   = 1'b0;
        e_cv    = 1'b0;
        e_cidx  = '0;
        e_we    = 1'b0;
        e_waddr = '0;
        e_wdata = '0;
    endtask

    // Advance the model by one clock edge using the state before the edge
    task automatic model_step(input logic av, input logic [4:0] rd, input logic wv,
                              input logic [2:0] wi, input logic [31:0] wd, input logic st);
        bit in_q;
        bit wb_legal;
        bit commit;
        bit alloc;
        int t;
        in_q = 1'b0;
        for (int k = 0; k < m_q.size(); k++)
            if (m_q[k] == int'(wi)) in_q = 1'b1;
        wb_legal = wv && in_q && !m_rdy[wi];
        commit   = (m_q.size() > 0) && m_rdy[m_q[0]] && !st;
        alloc    = av && (m_q.size() < DEPTH);
        e_cv = commit;
        e_we = 1'b0;
        if (commit) begin
            t        = m_q.pop_front();
            e_cidx   = 3'(t);
            e_waddr  = m_rd[t];
            e_wdata  = m_val[t];
            e_we     = (m_rd[t] != 5'd0);
            m_rdy[t] = 1'b0;
        end
        if (alloc) begin
            m_q.push_back(m_tail);
            m_rdy[m_tail] = 1'b0;
            m_rd[m_tail]  = rd;
            m_tail        = (m_tail + 1) % DEPTH;
        end
        if (wv) begin
            if (wb_legal) begin
                m_val[wi] = wd;
                m_rdy[wi] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_registered();
        check("commit_valid", 32'(commit_valid), 32'(e_cv));
        if (e_cv) check("commit_idx", 32'(commit_idx), 32'(e_cidx));
        check("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            check("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
            check("rf_wdata", rf_wdata, e_wdata);
        end
        check("rob_count", 32'(rob_count), 32'(m_q.size()));
        check("rob_empty", 32'(rob_empty), 32'(m_q.size() == 0));
        check("wb_err", 32'(wb_err), 32'(m_err));
    endtask

    // Drive one cycle of inputs, check combinational outputs, clock, check registered outputs
    task automatic apply_stimulus(input logic av, input logic [4:0] rd, input logic wv,
                                  input logic [2:0] wi, input logic [31:0] wd, input logic st);
        alloc_valid  = av;
        alloc_rd     = rd;
        wb_valid     = wv;
        wb_idx       = wi;
        wb_value     = wd;
        commit_stall = st;
        #1;
        check("alloc_ready", 32'(alloc_ready), 32'(m_q.size() < DEPTH));
        check("alloc_idx", 32'(alloc_idx), 32'(m_tail));
        model_step(av, rd, wv, wi, wd, st);
        @(posedge clk);
        #1;
        check_registered();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    // Inputs stay active during reset to show they are discarded
    task automatic reset_dut();
        rst          = 1'b1;
        alloc_valid  = 1'b1;
        alloc_rd     = 5'd1;
        wb_valid     = 1'b0;
        wb_idx       = 3'd0;
        wb_value     = 32'd0;
        commit_stall = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        alloc_valid = 1'b0;
        model_reset();
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_commit_idx", 32'(commit_idx), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_rob_count", 32'(rob_count), 32'd0);
        check("rst_rob_empty", 32'(rob_empty), 32'd1);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    endtask

    initial begin
        int pend[$];
        logic        r_av;
        logic [4:0]  r_rd;
        logic        r_wv;
        logic [2:0]  r_wi;
        logic [31:0] r_wd;
        logic        r_st;

        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        wb_valid     = 1'b0;
        wb_idx       = '0;
        wb_value     = '0;
        commit_stall = 1'b0;
        model_reset();

        //           av    rd     wv    wi    wd          st    cnt   cv    cidx  we    waddr  wdata
        tbl[0] = '{1'b1, 5'd3, 1'b0, 3'd0, 32'h00,    1'b0, 4'd1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h00};
        tbl[1] = '{1'b1, 5'd4, 1'b0, 3'd0, 32'h00,    1'b0, 4'd2, 1'b0, 3'd0, 1'b0, 5'd0, 32'h00};
        tbl[2] = '{1'b1, 5'd5, 1'b1, 3'd0, 32'h11,    1'b0, 4'd3, 1'b0, 3'd0, 1'b0, 5'd0, 32'h00};
        tbl[3] = '{1'b0, 5'd0, 1'b1, 3'd1, 32'h22,    1'b0, 4'd2, 1'b1, 3'd0, 1'b1, 5'd3, 32'h11};
        tbl[4] = '{1'b0, 5'd0, 1'b1, 3'd2, 32'h33,    1'b0, 4'd1, 1'b1, 3'd1, 1'b1, 5'd4, 32'h22};
        tbl[5] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00,    1'b0, 4'd0, 1'b1, 3'd2, 1'b1, 5'd5, 32'h33};
        tbl[6] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00,    1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h00};

        reset_dut();
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(tbl[i].av, tbl[i].rd, tbl[i].wv, tbl[i].wi, tbl[i].wd, tbl[i].st);
            check($sformatf("tbl%0d_count", i), 32'(rob_count), 32'(tbl[i].e_count));
            check($sformatf("tbl%0d_cv", i), 32'(commit_valid), 32'(tbl[i].e_cv));
            check($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
            if (tbl[i].e_cv) check($sformatf("tbl%0d_cidx", i), 32'(commit_idx), 32'(tbl[i].e_cidx));
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_waddr));
                check($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wdata);
            end
        end

        // Younger entry ready first must wait behind the head
        reset_dut();
        apply_stimulus(1'b1, 5'd7, 1'b0, 3'd0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 5'd8, 1'b0, 3'd0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'hAA, 1'b0);
        idle(3);
        check("ooo_no_we", 32'(rf_we), 32'd0);
        apply_stimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'hBB, 1'b0);
        check("ooo_wb_cycle_we", 32'(rf_we), 32'd0);
        idle(1);
        check("ooo_first_data", rf_wdata, 32'hBB);
        check("ooo_first_we", 32'(rf_we), 32'd1);
        idle(1);
        check("ooo_second_data", rf_wdata, 32'hAA);
        check("ooo_second_addr", 32'(rf_waddr), 32'd8);
        idle(1);

        // Full boundary: extra allocate ignored, commit frees a slot only the cycle after
        reset_dut();
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0, 1'b0);
        check("full_ready_low", 32'(alloc_ready), 32'd0);
        check("full_count", 32'(rob_count), 32'd8);
        apply_stimulus(1'b1, 5'd20, 1'b0, 3'd0, 32'h0, 1'b0);
        check("full_extra_ignored", 32'(rob_count), 32'd8);
        apply_stimulus(1'b1, 5'd21, 1'b1, 3'd0, 32'h77, 1'b0);
        apply_stimulus(1'b1, 5'd22, 1'b0, 3'd0, 32'h0, 1'b0);
        check("full_commit_count", 32'(rob_count), 32'd7);
        check("full_ready_after", 32'(alloc_ready), 32'd1);
        apply_stimulus(1'b1, 5'd23, 1'b0, 3'd0, 32'h0, 1'b0);
        check("full_refill", 32'(rob_count), 32'd8);

        // Stall holds a ready head
        reset_dut();
        apply_stimulus(1'b1, 5'd9, 1'b0, 3'd0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'h99, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1);
            check("stall_no_cv", 32'(commit_valid), 32'd0);
        end
        apply_stimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0);
        check("stall_release_cv", 32'(commit_valid), 32'd1);
        check("stall_release_data", rf_wdata, 32'h99);

        // rd==0 retires without a register write; then protocol errors
        reset_dut();
        apply_stimulus(1'b1, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'h5, 1'b0);
        idle(1);
        check("rd0_cv", 32'(commit_valid), 32'd1);
        check("rd0_we", 32'(rf_we), 32'd0);
        check("rd0_freed", 32'(rob_count), 32'd0);
        apply_stimulus(1'b0, 5'd0, 1'b1, 3'd3, 32'h1, 1'b0);
        check("err_free_idx", 32'(wb_err), 32'd1);
        idle(3);
        check("err_sticky", 32'(wb_err), 32'd1);
        reset_dut();
        apply_stimulus(1'b1, 5'd6, 1'b1, 3'd0, 32'h1, 1'b0);
        check("err_alloc_same_idx", 32'(wb_err), 32'd1);

        // Randomized traffic wrapping the pointers, then reset mid-stream
        reset_dut();
        for (int c = 0; c < 300; c++) begin
            pend.delete();
            foreach (m_q[k]) if (!m_rdy[m_q[k]]) pend.push_back(m_q[k]);
            r_av = ($urandom_range(0, 3) != 0);
            r_rd = 5'($urandom_range(0, 31));
            r_st = ($urandom_range(0, 4) == 0);
            r_wd = $urandom;
            r_wv = 1'b0;
            r_wi = 3'd0;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                r_wv = 1'b1;
                r_wi = 3'(pend[$urandom_range(0, pend.size() - 1)]);
            end
            apply_stimulus(r_av, r_rd, r_wv, r_wi, r_wd, r_st);
        end
        apply_stimulus(1'b1, 5'd2, 1'b0, 3'd0, 32'h0, 1'b0);
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0);
            check("post_rst_no_cv", 32'(commit_valid), 32'd0);
            check("post_rst_empty", 32'(rob_empty), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
